dram_responder: RTL and testbench
=================================

# dram_responder

Data-memory responder for the pipelined RV32I core: the memory-side end of the `dram_*` interface that the execute stage drives. It services one load or store at a time through a request/ready handshake, with a parameterised wait-state count. It byte-lane-masks SB/SH/SW stores and returns the full aligned word for loads; sign/zero extension stays in the MEM stage. It also flags misaligned accesses so the exception logic can raise a trap.

## Interface
- `ADDR_W`, 12: word-index bits; memory holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 0: extra wait states per access, legal range 0..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `dram_adr`  in  32  byte address.
- `dram_w_op`  in  2  store width: 00 SB, 01 SH, 10 SW, 11 reserved.
- `dram_we`  in  1  store request.
- `dram_re`  in  1  load request.
- `dram_wdin`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `dram_rdo`  out  32  aligned word read by the last completed load.
- `dram_ready`  out  1  one-cycle pulse: access complete.
- `dram_misalign`  out  1  pulses with `dram_ready` when the completed access was misaligned.

## Operation
- A request is active when `dram_we | dram_re` is high. The initiator holds `dram_adr`, `dram_w_op`, `dram_wdin`, `dram_we` and `dram_re` stable until it samples `dram_ready` high.
- Word index is `dram_adr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses alias modulo 4·2^ADDR_W bytes.
- If `dram_we` and `dram_re` are both high, the store wins and the load is ignored.
- Store lane mask is derived from `dram_adr[1:0]`:
  - SB writes lane `adr[1:0]` with `wdin[7:0]`.
  - SH writes lanes {adr[1],0} and {adr[1],1} with `wdin[15:0]`.
  - SW writes all four lanes.
  - Lanes outside the mask keep their old bytes.
- Reserved `w_op` 11 on a store: no memory change; the access completes normally with `dram_misalign`=0.
- Misalignment is SH with adr[0]=1, or SW with adr[1:0]≠0, and is checked for both loads and stores. A load's width comes from `dram_w_op`; the MEM stage drives it from `mem_ext_op`. Handling depends on the Configuration macro below.
- Load: the access edge latches `mem[index]` into `dram_rdo`. `dram_rdo` holds that value until the next completed load; stores leave it unchanged.
- State machine, 3 states:
  - IDLE: request high and WAIT_CYCLES=0 → perform access, go to RESP. Request high and WAIT_CYCLES>0 → load `cnt`=WAIT_CYCLES, go to WAIT.
  - WAIT: request low → abort to IDLE with no memory change (pipeline flush). Request high and cnt>1 → cnt−1. Request high and cnt=1 → perform access, go to RESP.
  - RESP: `dram_ready`=1 for exactly this cycle, then unconditionally go to IDLE. A request still high in RESP is not re-accepted.
- Memory contents are not reset and are undefined at power-up.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0
  - `dram_ready` = 0, `dram_misalign` = 0, `dram_rdo` = 32'h0
- Reset asserted mid-access returns to IDLE immediately. A store is either fully committed or not at all; it is never partial.
- Latency: `dram_ready` is high WAIT_CYCLES+1 cycles after the first cycle the request is presented.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles. A new request may be presented in the cycle after RESP.
- `dram_ready`, `dram_misalign` and `dram_rdo` are registered outputs; there is no combinational path from inputs to outputs.
- MEM stage usage: `mem_ready_go` = `dram_ready` for memory instructions.

## Configuration
- `DRAM_MISALIGN_EN` defined:
  - Misaligned stores do not modify memory.
  - Misaligned loads still update `dram_rdo` with the word at the index.
  - `dram_misalign` pulses with `dram_ready` for any misaligned access.
- `DRAM_MISALIGN_EN` undefined:
  - `dram_misalign` is tied to 0.
  - SH lane selection uses adr[1] only; SW ignores adr[1:0].
  - All stores are performed.

## Test plan
- WAIT_CYCLES=0: SW adr 0x10 wdin 0xDEADBEEF, then load adr 0x10 → `dram_ready` 1 cycle after each request; `dram_rdo`=0xDEADBEEF.
- Byte lanes: after the word above, SB adr 0x13 wdin 0x000000AA, then SH adr 0x10 wdin 0x00001234, then load 0x10 → `dram_rdo`=0xAAAD1234.
- WAIT_CYCLES=3: load adr 0x10 → `dram_ready` exactly 4 cycles after the request. Drop the request after 2 cycles on a second store → no ready pulse, memory unchanged.
- Misalign (macro defined): SW adr 0x12 wdin 0x11111111 → `dram_ready`=`dram_misalign`=1 and word 0x10 unchanged. With the macro undefined: word 0x10 becomes 0x11111111 and `dram_misalign`=0.
- Simultaneous `dram_we`=`dram_re`=1, SW adr 0x20 wdin 0x5 → store performed, `dram_rdo` unchanged. Aliasing: with ADDR_W=12, load at adr 0x4020 → 0x5.
- Assert `rst_n`=0 during WAIT of a store → outputs return to reset values asynchronously and the target word is unchanged.

Source files
------------

// File: rtl/dram_responder_if.sv
// ---------------------------------------------------------------------------
// dram_responder_if
//
// The dram_* bus between the execute/MEM stages of the RV32I core (master)
// and the data-memory responder (slave).
//
// Signals:
//   dram_adr      master->slave  32  byte address
//   dram_w_op     master->slave   2  access width: 00 byte, 01 half, 10 word, 11 reserved
//   dram_we       master->slave   1  store request
//   dram_re       master->slave   1  load request
//   dram_wdin     master->slave  32  store data, right-aligned
//   dram_rdo      slave->master  32  aligned word from the last completed load
//   dram_ready    slave->master   1  one-cycle completion pulse
//   dram_misalign slave->master   1  pulses with dram_ready for a misaligned access
// ---------------------------------------------------------------------------
interface dram_responder_if;
  logic [31:0] dram_adr;
  logic [1:0]  dram_w_op;
  logic        dram_we;
  logic        dram_re;
  logic [31:0] dram_wdin;
  logic [31:0] dram_rdo;
  logic        dram_ready;
  logic        dram_misalign;

  modport master (
    output dram_adr, dram_w_op, dram_we, dram_re, dram_wdin,
    input  dram_rdo, dram_ready, dram_misalign
  );

  modport slave (
    input  dram_adr, dram_w_op, dram_we, dram_re, dram_wdin,
    output dram_rdo, dram_ready, dram_misalign
  );
endinterface

// File: rtl/dram_responder.sv
// ---------------------------------------------------------------------------
// dram_responder
//
// Memory-side end of the dram_* bus of the pipelined RV32I core. Services one
// load or store at a time with WAIT_CYCLES extra wait states, byte-lane masks
// SB/SH/SW stores and returns the full aligned word for loads (sign/zero
// extension is done by the MEM stage).
//
// Parameters:
//   ADDR_W       word-index bits; the array holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES  extra wait states per access, 0..15
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   dram         dram_responder_if.slave (see the interface for signals)
//
// Build option:
//   DRAM_MISALIGN_EN  when defined, misaligned SH/SW stores are suppressed and
//                     dram_misalign pulses with dram_ready for any misaligned
//                     load or store. When undefined, dram_misalign is always 0,
//                     SH picks its half from adr[1], SW ignores adr[1:0] and
//                     every store is performed.
// ---------------------------------------------------------------------------
module dram_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dram_responder_if.slave        dram
);

  // Access FSM encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Wait-state counter start value; only the low four bits are meaningful
  // because WAIT_CYCLES is restricted to 0..15.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [31:0]       mem [2**ADDR_W];

  logic              req;
  logic              do_access;
  logic [ADDR_W-1:0] index;
  logic [3:0]        lane_base;
  logic [3:0]        lane_en;
  logic [31:0]       lane_data;
  logic              misaligned;

  // Address bits above the word index alias; they are deliberately dropped.
  logic              unused_adr_hi;
  assign unused_adr_hi = ^dram.dram_adr[31:ADDR_W+2];

  assign req   = dram.dram_we | dram.dram_re;
  assign index = dram.dram_adr[ADDR_W+1:2];

  // The single edge on which memory is written or read. Gating with rst_n
  // keeps an IDLE-state request from touching memory while reset is held.
  assign do_access = rst_n && req &&
                     (((state == S_IDLE) && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && (cnt <= 4'd1)));

  // Byte lanes touched by the store and the data replicated onto them.
  // NOTE: every output of a combinational block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    lane_base = 4'b0000;
    lane_data = dram.dram_wdin;
    case (dram.dram_w_op)
      2'b00: begin
        lane_base = 4'b0001 << dram.dram_adr[1:0];
        lane_data = {4{dram.dram_wdin[7:0]}};
      end
      2'b01: begin
        lane_base = dram.dram_adr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{dram.dram_wdin[15:0]}};
      end
      2'b10:   lane_base = 4'b1111;
      default: lane_base = 4'b0000;  // reserved width: no memory change
    endcase
  end

`ifdef DRAM_MISALIGN_EN
  // Loads and stores share the width encoding, so the same test covers both.
  assign misaligned = ((dram.dram_w_op == 2'b01) && dram.dram_adr[0]) ||
                      ((dram.dram_w_op == 2'b10) && (dram.dram_adr[1:0] != 2'b00));
  assign lane_en    = misaligned ? 4'b0000 : lane_base;
`else
  assign misaligned = 1'b0;
  assign lane_en    = lane_base;
`endif

  // Storage array.
  // NOTE: the memory array has no reset; its power-up contents are undefined
  // and clearing it would need one write port per word.
  always_ff @(posedge clk) begin
    if (do_access && dram.dram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[index][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end
    end
  end

  // Control FSM and registered outputs.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      cnt                <= 4'd0;
      dram.dram_ready    <= 1'b0;
      dram.dram_misalign <= 1'b0;
      dram.dram_rdo      <= 32'h0;
    end else begin
      dram.dram_ready    <= 1'b0;
      dram.dram_misalign <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req) begin
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              cnt   <= WAIT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            // Pipeline flush: abandon the access with no memory change.
            cnt   <= 4'd0;
            state <= S_IDLE;
          end else if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else begin
            cnt   <= 4'd0;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          // A request still held here is the one just completed; the
          // initiator drops it after seeing dram_ready.
          state <= S_IDLE;
        end
        default: begin
          cnt   <= 4'd0;
          state <= S_IDLE;
        end
      endcase

      if (do_access) begin
        dram.dram_ready    <= 1'b1;
        dram.dram_misalign <= misaligned;
        // A store wins over a simultaneous load; stores leave dram_rdo alone.
        if (!dram.dram_we && dram.dram_re) begin
          dram.dram_rdo <= mem[index];
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// ---------------------------------------------------------------------------
// tb_dram_responder
//
// Two responders share clk/rst_n: dut_a with no wait states and dut_b with
// three. Stimulus pushes the expected {dram_rdo, dram_misalign} of every
// access into a per-DUT queue; a monitor per DUT pops and compares whenever
// dram_ready is seen. Latency, abort and reset behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_dram_responder;

`ifdef DRAM_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdo;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  dram_responder_if if_a ();
  dram_responder_if if_b ();

  dram_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .dram  (if_a)
  );

  dram_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .dram  (if_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && if_a.dram_ready) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        check("a_rdo", if_a.dram_rdo, e.rdo);
        check("a_misalign", {31'd0, if_a.dram_misalign}, {31'd0, e.mis});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && if_b.dram_ready) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        check("b_rdo", if_b.dram_rdo, e.rdo);
        check("b_misalign", {31'd0, if_b.dram_misalign}, {31'd0, e.mis});
      end
    end
  end

  task automatic drive(input int sel, input logic [31:0] adr, input logic [1:0] wop,
                       input logic we, input logic re, input logic [31:0] wdin);
    if (sel == 0) begin
      if_a.dram_adr  = adr;
      if_a.dram_w_op = wop;
      if_a.dram_we   = we;
      if_a.dram_re   = re;
      if_a.dram_wdin = wdin;
    end else begin
      if_b.dram_adr  = adr;
      if_b.dram_w_op = wop;
      if_b.dram_we   = we;
      if_b.dram_re   = re;
      if_b.dram_wdin = wdin;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? if_a.dram_ready : if_b.dram_ready;
  endfunction

  // One complete access: queue the expectation, present the request on a
  // falling edge, count cycles until dram_ready, then release the bus.
  task automatic access(input int sel, input string name, input logic [31:0] adr,
                        input logic [1:0] wop, input logic we, input logic re,
                        input logic [31:0] wdin, input logic [31:0] exp_rdo,
                        input logic exp_mis, input int exp_lat);
    exp_t e;
    int   lat;
    e.rdo = exp_rdo;
    e.mis = exp_mis;
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
    @(negedge clk);
    drive(sel, adr, wop, we, re, wdin);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!get_ready(sel) && lat < 40);
    check({name, "_latency"}, lat, exp_lat);
    drive(sel, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  logic [31:0] w10;
  int          seen;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0;
    drive(0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    drive(1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("a_reset_rdo",      if_a.dram_rdo, 32'h0);
    check("a_reset_ready",    {31'd0, if_a.dram_ready}, 32'd0);
    check("a_reset_misalign", {31'd0, if_a.dram_misalign}, 32'd0);
    check("b_reset_rdo",      if_b.dram_rdo, 32'h0);

    // ---- dut_a, no wait states ----
    access(0, "a_sw10",  32'h10, 2'b10, 1, 0, 32'hDEADBEEF, 32'h0,        0, 1);
    access(0, "a_lw10",  32'h10, 2'b10, 0, 1, 32'h0,        32'hDEADBEEF, 0, 1);
    access(0, "a_sb13",  32'h13, 2'b00, 1, 0, 32'h000000AA, 32'hDEADBEEF, 0, 1);
    access(0, "a_sh10",  32'h10, 2'b01, 1, 0, 32'h00001234, 32'hDEADBEEF, 0, 1);
    access(0, "a_lw10b", 32'h10, 2'b10, 0, 1, 32'h0,        32'hAAAD1234, 0, 1);

    // Misaligned SW: suppressed and flagged with the option, performed without.
    w10 = MIS_EN ? 32'hAAAD1234 : 32'h11111111;
    access(0, "a_sw12",  32'h12, 2'b10, 1, 0, 32'h11111111, 32'hAAAD1234, MIS_EN, 1);
    access(0, "a_lw10c", 32'h10, 2'b10, 0, 1, 32'h0,        w10,          0, 1);

    // Store wins over a simultaneous load; then aliasing past 4*2^12 bytes.
    access(0, "a_swre20", 32'h20,   2'b10, 1, 1, 32'h00000005, w10,          0, 1);
    access(0, "a_lw4020", 32'h4020, 2'b10, 0, 1, 32'h0,        32'h00000005, 0, 1);
    access(0, "a_sb21",   32'h21,   2'b00, 1, 0, 32'h00000077, 32'h00000005, 0, 1);
    access(0, "a_lw20",   32'h20,   2'b10, 0, 1, 32'h0,        32'h00007705, 0, 1);

    // Reserved width store leaves memory alone and is never flagged.
    access(0, "a_rsv10", 32'h10, 2'b11, 1, 0, 32'hFFFFFFFF, 32'h00007705, 0, 1);
    // Misaligned half load still returns the word at the index.
    access(0, "a_lh11",  32'h11, 2'b01, 0, 1, 32'h0, w10, MIS_EN, 1);
    access(0, "a_lh12",  32'h12, 2'b01, 0, 1, 32'h0, w10, 0,      1);

    // ---- dut_b, three wait states ----
    access(1, "b_sw10",  32'h10, 2'b10, 1, 0, 32'hCAFEF00D, 32'h0,        0, 4);
    access(1, "b_lw10",  32'h10, 2'b10, 0, 1, 32'h0,        32'hCAFEF00D, 0, 4);

    // Store dropped after two cycles in WAIT: no ready, no memory change.
    @(negedge clk);
    drive(1, 32'h10, 2'b10, 1'b1, 1'b0, 32'h0BADBEEF);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (if_b.dram_ready) seen++;
    end
    drive(1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    repeat (8) begin
      @(negedge clk);
      if (if_b.dram_ready) seen++;
    end
    check("b_abort_no_ready", seen, 32'd0);
    access(1, "b_lw10_after_abort", 32'h10, 2'b10, 0, 1, 32'h0, 32'hCAFEF00D, 0, 4);

    // Reset asserted while a store is waiting.
    @(negedge clk);
    drive(1, 32'h10, 2'b10, 1'b1, 1'b0, 32'h12345678);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("b_rst_rdo",      if_b.dram_rdo, 32'h0);
    check("b_rst_ready",    {31'd0, if_b.dram_ready}, 32'd0);
    check("b_rst_misalign", {31'd0, if_b.dram_misalign}, 32'd0);
    check("a_rst_rdo",      if_a.dram_rdo, 32'h0);
    drive(1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1, "b_lw10_after_rst", 32'h10, 2'b10, 0, 1, 32'h0, 32'hCAFEF00D, 0, 4);
    access(0, "a_lw10_after_rst", 32'h10, 2'b10, 0, 1, 32'h0, w10,          0, 1);

    repeat (3) @(negedge clk);
    check("a_queue_empty", q_a.size(), 32'd0);
    check("b_queue_empty", q_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
